serial_bit_feeder: RTL and testbench

- Upstream stage for the Moore sequence-detector FSM.
- Accepts a parallel word through a valid/ready handshake and serialises it one bit per clock onto a single line that drives the detector's serial `in` input.
- Provides framing status so that test sequences such as 1011 or 0110 can be injected from a register or CPU write instead of hand-timed stimulus.

---
 rtl/serial_bit_feeder.sv | 162 ++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial bit feeder for the sequence-detector input line.
// Optional even-parity trailer cycle when SERIAL_PARITY_EN is defined.
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             out_bit,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_bit_q, out_bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             last_bit;
    logic             accept;
    logic             go_idle;
    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             first_bit;

    // The register keeps the bit on out_bit at the shift-out end.
    always_comb begin
        if (MSB_FIRST) begin
            shifted   = shreg_q << 1;
            next_bit  = shreg_q[WIDTH-2];
            first_bit = data_in[WIDTH-1];
        end else begin
            shifted   = shreg_q >> 1;
            next_bit  = shreg_q[1];
            first_bit = data_in[0];
        end
    end

    always_comb begin
`ifdef SERIAL_PARITY_EN
        last_bit = (state_q == PAR);
`else
        last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`endif
        load_ready = (state_q == IDLE) || (last_bit && !hold);
        accept     = load_valid && load_ready;
        // Gated by the live hold so a held final bit defers the pulse.
        frame_done = last_bit && !hold;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_bit_d   = out_bit_q;
        bit_valid_d = bit_valid_q;
        busy_d      = busy_q;
`ifdef SERIAL_PARITY_EN
        par_d       = par_q;
`endif
        go_idle     = 1'b0;

        unique case (state_q)
            IDLE: begin
                go_idle = 1'b0;
            end
            SHIFT: begin
                if (!hold) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d     = cnt_q + 1'b1;
                        shreg_d   = shifted;
                        out_bit_d = next_bit;
                    end else begin
`ifdef SERIAL_PARITY_EN
                        state_d   = PAR;
                        out_bit_d = par_q;
`else
                        go_idle   = !accept;
`endif
                    end
                end
            end
            PAR: begin
                if (!hold) begin
                    go_idle = !accept;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_bit_d   = IDLE_BIT;
            bit_valid_d = 1'b0;
            busy_d      = 1'b0;
        end

        if (accept) begin
            state_d     = SHIFT;
            shreg_d     = data_in;
            cnt_d       = '0;
            out_bit_d   = first_bit;
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
`ifdef SERIAL_PARITY_EN
            par_d       = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_bit_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign out_bit   = out_bit_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder (MSB-first and LSB-first instances).
// Frame length follows SERIAL_PARITY_EN.
module tb_serial_bit_feeder;

    localparam int W = 8;
`ifdef SERIAL_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din, din2;
    logic         lv, lv2;
    logic         hold, hold2;
    logic         lr, lr2;
    logic         ob, ob2;
    logic         bv, bv2;
    logic         bsy, bsy2;
    logic         fd, fd2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .data_in(din), .load_valid(lv),
        .load_ready(lr), .hold(hold), .out_bit(ob), .bit_valid(bv),
        .busy(bsy), .frame_done(fd)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(din2), .load_valid(lv2),
        .load_ready(lr2), .hold(hold2), .out_bit(ob2), .bit_valid(bv2),
        .busy(bsy2), .frame_done(fd2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected frame bit i of word w; index W is the even-parity trailer.
    function automatic logic eb(input logic [W-1:0] w, input int i,
                                input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    initial begin
        rst = 1'b1; din = '0; din2 = '0;
        lv = 1'b0; lv2 = 1'b0; hold = 1'b0; hold2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_bit", ob, 0);
        chk("rst_bit_valid", bv, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_frame_done", fd, 0);
        chk("rst_load_ready", lr, 1);
        chk("rst_lsb_ready", lr2, 1);

        // Basic frame 8'hB4 -> 1,0,1,1,0,1,0,0
        din = 8'hB4; lv = 1'b1;
        step();
        lv = 1'b0; din = 8'hFF;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("basic_bit%0d", i), ob, eb(8'hB4, i, 1'b1));
            chk($sformatf("basic_valid%0d", i), bv, 1);
            chk($sformatf("basic_busy%0d", i), bsy, 1);
            chk($sformatf("basic_done%0d", i), fd, (i == FL - 1));
            chk($sformatf("basic_ready%0d", i), lr, (i == FL - 1));
            step();
        end
        chk("basic_idle_bit", ob, 0);
        chk("basic_idle_valid", bv, 0);
        chk("basic_idle_busy", bsy, 0);
        chk("basic_idle_ready", lr, 1);
        chk("basic_literal", {eb(8'hB4, 0, 1'b1), eb(8'hB4, 2, 1'b1)}, 2'b11);

        // Back-to-back 8'hB4 then 8'h0F, gapless
        din = 8'hB4; lv = 1'b1;
        step();
        din = 8'h0F;
        for (int i = 0; i < 2 * FL; i++) begin
            chk($sformatf("b2b_bit%0d", i), ob,
                (i < FL) ? eb(8'hB4, i, 1'b1) : eb(8'h0F, i - FL, 1'b1));
            chk($sformatf("b2b_valid%0d", i), bv, 1);
            chk($sformatf("b2b_done%0d", i), fd,
                (i == FL - 1) || (i == 2 * FL - 1));
            step();
            if (i == FL - 1) lv = 1'b0;
        end
        chk("b2b_end_valid", bv, 0);
        chk("b2b_end_busy", bsy, 0);

        // Hold for two cycles while bit 3 is on the line
        din = 8'hB4; lv = 1'b1;
        step();
        lv = 1'b0;
        for (int c = 1; c <= FL + 2; c++) begin
            int idx;
            hold = (c == 4) || (c == 5);
            idx = (c <= 3) ? c - 1 : (c <= 6) ? 3 : c - 3;
            chk($sformatf("hold_bit_c%0d", c), ob, eb(8'hB4, idx, 1'b1));
            chk($sformatf("hold_valid_c%0d", c), bv, 1);
            chk($sformatf("hold_ready_c%0d", c), lr, (c == FL + 2));
            chk($sformatf("hold_done_c%0d", c), fd, (c == FL + 2));
            step();
        end
        hold = 1'b0;
        chk("hold_end_valid", bv, 0);

        // Reset while bit 4 is on the line
        din = 8'hB4; lv = 1'b1;
        step();
        lv = 1'b0;
        step();
        step();
        step();
        step();
        chk("rstmid_bit4", ob, eb(8'hB4, 4, 1'b1));
        chk("rstmid_busy_before", bsy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_out_bit", ob, 0);
        chk("rstmid_valid", bv, 0);
        chk("rstmid_busy", bsy, 0);
        chk("rstmid_ready", lr, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rstmid_nodone%0d", i), fd, 0);
            step();
        end

        // LSB-first 8'h01; a pulse of 8'hFF mid-frame is ignored
        din2 = 8'h01; lv2 = 1'b1;
        step();
        lv2 = 1'b0; din2 = 8'h00;
        for (int i = 0; i < FL; i++) begin
            if (i == 2) begin
                din2 = 8'hFF; lv2 = 1'b1;
                chk("lsb_pulse_ready", lr2, 0);
            end
            chk($sformatf("lsb_bit%0d", i), ob2, eb(8'h01, i, 1'b0));
            chk($sformatf("lsb_done%0d", i), fd2, (i == FL - 1));
            step();
            lv2 = 1'b0; din2 = 8'h00;
        end
        chk("lsb_end_valid", bv2, 0);
        chk("lsb_end_bit", ob2, 0);

`ifdef SERIAL_PARITY_EN
        // Parity trailer for 8'h07 is 1
        din = 8'h07; lv = 1'b1;
        step();
        lv = 1'b0;
        for (int i = 0; i < W; i++) step();
        chk("par07_bit", ob, 1);
        chk("par07_done", fd, 1);
        chk("par07_valid", bv, 1);
        step();
        chk("par07_end_valid", bv, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
